rate_scaler_readout_arb: RTL and testbench
==========================================

Name: rate_scaler_readout_arb

Overview:
- Collects per-channel rate-scaler results (one P_N_WIDTH count per channel per counting period) from P_N_CH rate_scaler_four_lane instances.
- Holds each result in a one-deep per-channel buffer.
- Round-robin arbitrates the buffered results onto a single valid/ready readout stream toward the readout FIFO.
- Flags results overwritten before readout.

Parameters:
- P_N_CH, 4, number of rate-scaler channels served (2..16).
- P_N_WIDTH, 16, count width per channel.
- P_CH_W, 2, channel-index width; requirement 2**P_CH_W >= P_N_CH.
- P_SEQ_W, 8, readout sequence-number width.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  P_N_CH  per-channel enable mask.
- ch_update  in  P_N_CH  per-channel update strobe from the scaler.
- ch_valid  in  P_N_CH  per-channel valid status from the scaler.
- ch_cnt  in  P_N_CH*P_N_WIDTH  flattened counts; channel i occupies bits [i*P_N_WIDTH +: P_N_WIDTH].
- out_valid  out  1  readout word present.
- out_ready  in  1  downstream accept.
- out_ch  out  P_CH_W  channel index of the word.
- out_cnt  out  P_N_WIDTH  captured count.
- out_cnt_valid  out  1  ch_valid sampled at capture.
- out_lost  out  1  at least one earlier result on this channel was overwritten unread.
- out_seq  out  P_SEQ_W  transfer sequence number.
- pending  out  P_N_CH  per-channel buffer-occupied flags.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-release use): all outputs 0; all hold, pend and lost registers 0; rr pointer 0; out_seq 0. Reset mid-transfer discards everything, including the word on the output.
- Capture:
  - Trigger: rising clk with ch_update[i] && ch_en[i].
  - Action: hold_cnt[i] <= slice i; hold_vld[i] <= ch_valid[i]; pend[i] <= 1.
  - If pend[i] was already 1 and channel i is not popped in this cycle: lost[i] <= 1 (sticky until popped).
  - ch_update on a disabled channel is ignored.
- Pop/load:
  - The output stage loads when (!out_valid || out_ready) && |pend_eligible, where pend_eligible = pend & ch_en.
  - Grant: the first eligible channel searching upward from rr_ptr, modulo P_N_CH.
  - On load: out_ch, out_cnt, out_cnt_valid, out_lost <= granted channel's hold and lost values; pend[g] <= 0; lost[g] <= 0; rr_ptr <= g+1 (wraps to 0 after P_N_CH-1); out_valid <= 1.
- Simultaneous capture and pop on the same channel: the new capture wins. pend stays 1, the new data is stored, and lost is NOT set, because the old data was delivered.
- Output handshake:
  - While out_valid && !out_ready, all out_* fields hold stable.
  - If out_valid && out_ready and nothing is eligible, out_valid <= 0 next cycle.
  - Back-to-back transfers give one word per clk.
- out_seq increments by 1 on each accepted transfer (out_valid && out_ready), wrapping 2**P_SEQ_W-1 -> 0. It always labels the word currently presented.
- Latency: ch_update at edge t -> pend at t+1 -> out_valid at t+2, provided the output is idle and no higher-priority channel is pending.
- Disabling a channel (ch_en[i] falls): pend[i] and lost[i] clear on the next edge. A word already in the output stage is unaffected.
- Fairness: with all channels pending continuously, each channel is granted once per P_N_CH transfers.
- pending = pend, registered.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 -> all outputs 0 immediately (async); after release, first word has out_seq=0.
- Single channel: ch_update[2]=1, ch_cnt slice 2=16'h1234, ch_valid[2]=1, out_ready=1 -> two clk later out_valid=1, out_ch=2, out_cnt=16'h1234, out_cnt_valid=1, out_lost=0; then out_valid=0.
- Round robin: all four channels update in the same cycle with counts 10,20,30,40, out_ready=1 -> words on channels 0,1,2,3 on consecutive cycles, out_seq 0,1,2,3.
- Overwrite: out_ready=0; channel 1 updates 5 then 7 -> after out_ready=1, a single word: out_ch=1, out_cnt=7, out_lost=1. The next channel-1 word has out_lost=0.
- Back-pressure plus simultaneous capture/pop: hold out_ready=0 for 10 cycles -> fields stable. Then pulse ch_update[0] in the same cycle channel 0 is popped -> the following channel-0 word carries the new count with out_lost=0.
- Mask and wrap: ch_en[3]=0 while pend[3]=1 -> pending[3]=0 next cycle and ch_update[3] is ignored. Run 256 transfers -> out_seq wraps 255 -> 0.

Source files
------------

// File: rtl/rate_scaler_readout_arb.sv
// rate_scaler_readout_arb
// Gathers one count per channel per counting period into one-deep per-channel
// buffers, then round-robin arbitrates them onto a single readout stream.
// A buffer overwritten before it was read marks the next word from that
// channel with out_lost.
//
// Handshake: a word transfers on a rising clk where out_valid && out_ready.
// While out_valid is high and out_ready is low, every out_* field holds.
// out_valid never drops without a transfer, except on reset.
module rate_scaler_readout_arb #(
  parameter int P_N_CH    = 4,
  parameter int P_N_WIDTH = 16,
  parameter int P_CH_W    = 2,
  parameter int P_SEQ_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [P_N_CH-1:0]             ch_en,
  input  logic [P_N_CH-1:0]             ch_update,
  input  logic [P_N_CH-1:0]             ch_valid,
  input  logic [P_N_CH*P_N_WIDTH-1:0]   ch_cnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [P_CH_W-1:0]             out_ch,
  output logic [P_N_WIDTH-1:0]          out_cnt,
  output logic                          out_cnt_valid,
  output logic                          out_lost,
  output logic [P_SEQ_W-1:0]            out_seq,
  output logic [P_N_CH-1:0]             pending
);

  logic [P_N_WIDTH-1:0] hold_cnt [P_N_CH];
  logic [P_N_CH-1:0]    hold_vld;
  logic [P_N_CH-1:0]    pend;
  logic [P_N_CH-1:0]    lost;
  logic [P_N_CH-1:0]    pend_elig;
  logic [P_N_CH-1:0]    grant_oh;
  logic [P_N_CH-1:0]    pop_oh;
  logic [P_CH_W-1:0]    rr_ptr;
  logic [P_CH_W-1:0]    grant_ch;
  logic [P_CH_W-1:0]    rr_next;
  logic [P_N_WIDTH-1:0] sel_cnt;
  logic                 sel_vld;
  logic                 sel_lost;
  logic                 found;
  logic                 load;

  // Channel index base+k folded back into 0..P_N_CH-1 (base < P_N_CH, k <= P_N_CH).
  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= P_N_CH) ? s - P_N_CH : s;
  endfunction

  assign pend_elig = pend & ch_en;
  assign load      = (!out_valid || out_ready) && (|pend_elig);
  assign pop_oh    = load ? grant_oh : '0;
  assign pending   = pend;

  // Grant search: first eligible channel at or above rr_ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    grant_oh = '0;
    grant_ch = '0;
    rr_next  = '0;
    sel_cnt  = '0;
    sel_vld  = 1'b0;
    sel_lost = 1'b0;
    for (int k = 0; k < P_N_CH; k++) begin
      if (!found && pend_elig[wrap_idx(int'(rr_ptr), k)]) begin
        found                                = 1'b1;
        grant_oh[wrap_idx(int'(rr_ptr), k)] = 1'b1;
        grant_ch = P_CH_W'(wrap_idx(int'(rr_ptr), k));
        rr_next  = P_CH_W'(wrap_idx(int'(rr_ptr), k + 1));
        sel_cnt  = hold_cnt[wrap_idx(int'(rr_ptr), k)];
        sel_vld  = hold_vld[wrap_idx(int'(rr_ptr), k)];
        sel_lost = lost[wrap_idx(int'(rr_ptr), k)];
      end
    end
  end

  // Per-channel buffers: capture beats pop, disable clears pend/lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P_N_CH; i++) hold_cnt[i] <= '0;
      hold_vld <= '0;
      pend     <= '0;
      lost     <= '0;
    end else begin
      for (int i = 0; i < P_N_CH; i++) begin
        if (!ch_en[i]) begin
          pend[i] <= 1'b0;
          lost[i] <= 1'b0;
        end else if (ch_update[i]) begin
          hold_cnt[i] <= ch_cnt[i*P_N_WIDTH +: P_N_WIDTH];
          hold_vld[i] <= ch_valid[i];
          pend[i]     <= 1'b1;
          // Old data delivered this cycle means nothing was lost.
          if (pop_oh[i])    lost[i] <= 1'b0;
          else if (pend[i]) lost[i] <= 1'b1;
        end else if (pop_oh[i]) begin
          pend[i] <= 1'b0;
          lost[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage and round-robin pointer: load a granted word or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_cnt       <= '0;
      out_cnt_valid <= 1'b0;
      out_lost      <= 1'b0;
      rr_ptr        <= '0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_ch        <= grant_ch;
      out_cnt       <= sel_cnt;
      out_cnt_valid <= sel_vld;
      out_lost      <= sel_lost;
      rr_ptr        <= rr_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sequence number labels the presented word; advances on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_seq <= '0;
    end else if (out_valid && out_ready) begin
      out_seq <= out_seq + 1'b1;
    end
  end

endmodule

// File: tb/tb_rate_scaler_readout_arb.sv
// Directed bench for rate_scaler_readout_arb with hand-computed expectations.
module tb_rate_scaler_readout_arb;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = 2;
  localparam int SW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    ch_en;
  logic [N-1:0]    ch_update;
  logic [N-1:0]    ch_valid;
  logic [N*W-1:0]  ch_cnt;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_ch;
  logic [W-1:0]    out_cnt;
  logic            out_cnt_valid;
  logic            out_lost;
  logic [SW-1:0]   out_seq;
  logic [N-1:0]    pending;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW+W:0] exp_q[$];

  rate_scaler_readout_arb #(
    .P_N_CH(N), .P_N_WIDTH(W), .P_CH_W(CW), .P_SEQ_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_update(ch_update),
    .ch_valid(ch_valid), .ch_cnt(ch_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_cnt(out_cnt),
    .out_cnt_valid(out_cnt_valid), .out_lost(out_lost), .out_seq(out_seq),
    .pending(pending)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input int ch, input logic [W-1:0] v);
    ch_cnt[ch*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ch_en     = '1;
    ch_update = '0;
    ch_valid  = '0;
    ch_cnt    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [SW-1:0] exp_seq;
    logic [CW-1:0] exp_ch;
    logic [CW+W:0] exp_word;

    // reset state
    do_reset();
    check_eq("reset_state",
             {out_valid, out_ch, out_cnt, out_cnt_valid, out_lost, out_seq, pending}, '0);

    // single channel, latency 2
    out_ready = 1'b1;
    ch_update = 4'b0100;
    ch_valid  = 4'b0100;
    set_cnt(2, 16'h1234);
    tick();
    ch_update = '0;
    check_eq("single_pend", pending, 4'b0100);
    check_eq("single_not_yet", out_valid, 1'b0);
    tick();
    check_eq("single_word",
             {out_valid, out_ch, out_cnt, out_cnt_valid, out_lost, out_seq},
             {1'b1, 2'd2, 16'h1234, 1'b1, 1'b0, 8'd0});
    tick();
    check_eq("single_drain", {out_valid, pending}, 5'b0);

    // round robin: all four in one cycle
    do_reset();
    out_ready = 1'b1;
    ch_valid  = 4'b0101;
    for (int k = 0; k < N; k++) begin
      set_cnt(k, 16'((k + 1) * 10));
      exp_q.push_back({2'(k), 16'((k + 1) * 10), ((k % 2) == 0) ? 1'b1 : 1'b0});
    end
    ch_update = '1;
    tick();
    ch_update = '0;
    tick();
    for (int k = 0; k < N; k++) begin
      exp_word = exp_q.pop_front();
      check_eq("rr_valid", out_valid, 1'b1);
      check_eq("rr_word", {out_ch, out_cnt, out_cnt_valid}, exp_word);
      check_eq("rr_seq", out_seq, 8'(k));
      tick();
    end
    check_eq("rr_drain", out_valid, 1'b0);

    // overwrite while output is stalled
    do_reset();
    ch_update = 4'b0001;
    set_cnt(0, 16'd99);
    tick();
    ch_update = '0;
    tick();
    check_eq("ow_hold_ch0", {out_valid, out_ch}, {1'b1, 2'd0});
    ch_update = 4'b0010;
    set_cnt(1, 16'd5);
    tick();
    set_cnt(1, 16'd7);
    tick();
    ch_update = '0;
    check_eq("ow_pend", pending, 4'b0010);
    out_ready = 1'b1;
    tick();
    check_eq("ow_word", {out_valid, out_ch, out_cnt, out_lost, out_seq},
             {1'b1, 2'd1, 16'd7, 1'b1, 8'd1});
    tick();
    check_eq("ow_single", {out_valid, pending}, 5'b0);
    ch_update = 4'b0010;
    set_cnt(1, 16'd8);
    tick();
    ch_update = '0;
    tick();
    check_eq("ow_lost_cleared", {out_valid, out_ch, out_cnt, out_lost, out_seq},
             {1'b1, 2'd1, 16'd8, 1'b0, 8'd2});
    tick();

    // back-pressure then capture and pop on the same channel
    do_reset();
    ch_update = 4'b0010;
    set_cnt(1, 16'h0B0B);
    tick();
    ch_update = '0;
    tick();
    ch_update = 4'b0001;
    set_cnt(0, 16'hA1A1);
    tick();
    ch_update = '0;
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_stable", {out_valid, out_ch, out_cnt, pending},
               {1'b1, 2'd1, 16'h0B0B, 4'b0001});
      tick();
    end
    out_ready = 1'b1;
    ch_update = 4'b0001;
    set_cnt(0, 16'hA2A2);
    tick();
    ch_update = '0;
    check_eq("cap_pop_word", {out_valid, out_ch, out_cnt, out_lost, out_seq},
             {1'b1, 2'd0, 16'hA1A1, 1'b0, 8'd1});
    check_eq("cap_pop_pend", pending, 4'b0001);
    tick();
    check_eq("cap_pop_new", {out_valid, out_ch, out_cnt, out_lost, out_seq},
             {1'b1, 2'd0, 16'hA2A2, 1'b0, 8'd2});
    tick();
    check_eq("cap_pop_drain", {out_valid, pending}, 5'b0);

    // asynchronous reset with a word on the output
    ch_update = 4'b0100;
    out_ready = 1'b0;
    set_cnt(2, 16'h2222);
    tick();
    ch_update = '0;
    tick();
    check_eq("mid_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_zero",
             {out_valid, out_ch, out_cnt, out_cnt_valid, out_lost, out_seq, pending}, '0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    ch_update = 4'b1000;
    set_cnt(3, 16'h0055);
    tick();
    ch_update = '0;
    tick();
    check_eq("mid_first_word", {out_valid, out_ch, out_cnt, out_seq},
             {1'b1, 2'd3, 16'h0055, 8'd0});
    tick();

    // mask: disable a pending channel, updates on it ignored
    do_reset();
    ch_update = 4'b1001;
    set_cnt(0, 16'd1);
    set_cnt(3, 16'd3);
    tick();
    ch_update = '0;
    tick();
    check_eq("mask_pend", pending, 4'b1000);
    ch_en = 4'b0111;
    tick();
    check_eq("mask_cleared", pending, 4'b0000);
    ch_update = 4'b1000;
    tick();
    check_eq("mask_ignored", pending, 4'b0000);
    ch_update = '0;
    ch_en     = '1;
    out_ready = 1'b1;
    tick();
    check_eq("mask_drain", {out_valid, out_seq}, {1'b0, 8'd1});

    // wrap: continuous updates on all channels, one word per clock
    ch_update = '1;
    tick();
    tick();
    exp_seq = 8'd1;
    exp_ch  = 2'd1;
    for (int k = 0; k < 260; k++) begin
      check_eq("wrap_word", {out_valid, out_ch, out_seq}, {1'b1, exp_ch, exp_seq});
      tick();
      exp_seq = exp_seq + 8'd1;
      exp_ch  = exp_ch + 2'd1;
    end
    ch_update = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
